// File: rtl/div_reconstruct_seq_if.sv
// Operand/result handshake bundle for div_reconstruct_seq.
// The upstream (divider side) and downstream (result consumer) signals share one
// interface. master = the environment driving operands and consuming results,
// slave = the reconstructor itself. WIDTH must match the module's WIDTH.
interface div_reconstruct_seq_if #(
  parameter int WIDTH = 8
);
  // Operand side
  logic               valid_i;
  logic               ready_o;
  logic [WIDTH-1:0]   quot_i;
  logic [WIDTH-1:0]   div_i;
  logic [WIDTH-1:0]   rem_i;
  // Result side
  logic               valid_o;
  logic               ready_i;
  logic [2*WIDTH-1:0] dividend_o;
  logic               err_o;

  modport master (
    output valid_i, quot_i, div_i, rem_i, ready_i,
    input  ready_o, valid_o, dividend_o, err_o
  );

  modport slave (
    input  valid_i, quot_i, div_i, rem_i, ready_i,
    output ready_o, valid_o, dividend_o, err_o
  );
endinterface

// File: rtl/div_reconstruct_seq.sv
// Sequential divider inverse: dividend = quotient * divisor + remainder.
// One quotient bit is consumed per clock by shift-add into a 2*WIDTH accumulator
// seeded with the remainder, so the result always appears exactly WIDTH edges
// after the operands are accepted. Results wait in DONE until the consumer takes
// them.
// Optional feature: define REM_CHECK_EN to flag remainder >= divisor on err_o
// (an illegal divider output, which includes divide-by-zero). Without the macro
// err_o is constant 0 and no comparator is built.
module div_reconstruct_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  div_reconstruct_seq_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   q_sh_q;   // remaining multiplier bits, LSB is the current one
  logic [2*WIDTH-1:0] mcand_q;  // divisor, zero-extended
  logic [2*WIDTH-1:0] acc_q;    // running sum, seeded with the remainder
  logic [2*WIDTH-1:0] acc_d;
  logic [CNT_W-1:0]   cnt_q;    // bit position being added this cycle
  logic               ready;
  logic               accept;

  // Handshake decodes come straight from the state register.
  assign ready       = (state_q == ST_IDLE);
  assign accept      = bus.valid_i && ready;
  assign bus.ready_o = ready;
  assign bus.valid_o = (state_q == ST_DONE);
  assign bus.dividend_o = acc_q;

  // Partial-product add for the current quotient bit; zero bits leave acc unchanged.
  always_comb begin
    // NOTE: assign a default before any condition so every path writes acc_d;
    // a missing default here would infer a latch.
    acc_d = acc_q;
    if (q_sh_q[0]) begin
      acc_d = acc_q + (mcand_q << cnt_q);
    end
  end

`ifdef REM_CHECK_EN
  logic err_q;
  assign bus.err_o = err_q;

  // Remainder range flag: captured once at accept and held with the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= (bus.rem_i >= bus.div_i);
    end
  end
`else
  assign bus.err_o = 1'b0;
`endif

  // Control FSM and datapath registers: load at accept, shift-add in CALC,
  // hold in DONE until the consumer is ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: state is written with non-blocking assignments so every register
      // in this block updates from the same pre-edge values.
      state_q <= ST_IDLE;
      q_sh_q  <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            q_sh_q  <= bus.quot_i;
            mcand_q <= {{WIDTH{1'b0}}, bus.div_i};
            acc_q   <= {{WIDTH{1'b0}}, bus.rem_i};
            cnt_q   <= '0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q  <= acc_d;
          q_sh_q <= q_sh_q >> 1;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_reconstruct_seq.sv
// Self-checking bench for div_reconstruct_seq (WIDTH=8).
// A table of directed operand sets with hand-computed dividends is run first,
// then backpressure, mid-operation reset and a short random sweep.
module tb_div_reconstruct_seq;

  localparam int W = 8;

  logic clk_i;
  logic rst_ni;

  div_reconstruct_seq_if #(.WIDTH(W)) bus ();

  div_reconstruct_seq #(.WIDTH(W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic [7:0] d;
    logic [7:0] r;
    logic [15:0] exp_dividend;
    logic       exp_err_on;   // expected err_o when the range check is built in
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic exp_err(input logic err_on);
`ifdef REM_CHECK_EN
    return err_on;
`else
    return 1'b0;
`endif
  endfunction

  // Present one operand set, then count edges until valid_o. Returns at #1
  // after the edge where valid_o was first seen (DUT sitting in DONE).
  task automatic run_op(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                        output logic [15:0] res, output logic e, output int lat);
    int guard;
    guard = 0;
    @(negedge clk_i);
    while (!bus.ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    bus.valid_i = 1'b1;
    bus.quot_i  = q;
    bus.div_i   = d;
    bus.rem_i   = r;
    @(posedge clk_i);
    #1;
    // Scramble operands after accept; the result must not depend on them.
    bus.valid_i = 1'b0;
    bus.quot_i  = ~q;
    bus.div_i   = ~d;
    bus.rem_i   = ~r;
    lat = 0;
    while (!bus.valid_o && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    res = bus.dividend_o;
    e   = bus.err_o;
  endtask

  // Hand the result off and confirm the block is back in IDLE one edge later.
  task automatic release_result(input string name);
    @(negedge clk_i);
    bus.ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.ready_i = 1'b0;
    check({name, " ready_o after handoff"}, 32'(bus.ready_o), 32'd1);
    check({name, " valid_o after handoff"}, 32'(bus.valid_o), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [15:0] res;
    logic        e;
    int          lat;

    vecs[0] = '{"T1",     8'h0F, 8'h0D, 8'h05, 16'h00C8, 1'b0};
    vecs[1] = '{"T2",     8'hFF, 8'hFF, 8'hFE, 16'hFEFF, 1'b0};
    vecs[2] = '{"T3",     8'h37, 8'h00, 8'h09, 16'h0009, 1'b1};
    vecs[3] = '{"T4",     8'h05, 8'h0D, 8'h0D, 16'h004E, 1'b1};
    vecs[4] = '{"q0",     8'h00, 8'h12, 8'h03, 16'h0003, 1'b0};
    vecs[5] = '{"msb",    8'h80, 8'h80, 8'h7F, 16'h407F, 1'b0};
    vecs[6] = '{"q1",     8'h01, 8'hFF, 8'h00, 16'h00FF, 1'b0};
    vecs[7] = '{"alt",    8'hAA, 8'h55, 8'h10, 16'h3882, 1'b0};

    rst_ni      = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.quot_i  = '0;
    bus.div_i   = '0;
    bus.rem_i   = '0;
    #12;
    check("reset ready_o",    32'(bus.ready_o),    32'd1);
    check("reset valid_o",    32'(bus.valid_o),    32'd0);
    check("reset dividend_o", 32'(bus.dividend_o), 32'd0);
    check("reset err_o",      32'(bus.err_o),      32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].q, vecs[i].d, vecs[i].r, res, e, lat);
      check({vecs[i].name, " latency"},  32'(lat), 32'd8);
      check({vecs[i].name, " dividend"}, 32'(res), 32'(vecs[i].exp_dividend));
      check({vecs[i].name, " err"},      32'(e),   32'(exp_err(vecs[i].exp_err_on)));
      release_result(vecs[i].name);
    end

    // T5: backpressure in DONE with valid_i pulsing new operands
    run_op(8'h0F, 8'h0D, 8'h05, res, e, lat);
    check("T5 latency", 32'(lat), 32'd8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      bus.valid_i = k[0] ? 1'b1 : 1'b0;
      bus.quot_i  = 8'h11 + 8'(k);
      bus.div_i   = 8'h22;
      bus.rem_i   = 8'h01;
      @(posedge clk_i);
      #1;
      check("T5 hold dividend", 32'(bus.dividend_o), 32'h00C8);
      check("T5 hold valid_o",  32'(bus.valid_o),    32'd1);
      check("T5 hold ready_o",  32'(bus.ready_o),    32'd0);
      check("T5 hold err_o",    32'(bus.err_o),      32'd0);
    end
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.ready_i = 1'b0;
    check("T5 ready_o after handoff",  32'(bus.ready_o),    32'd1);
    check("T5 valid_o after handoff",  32'(bus.valid_o),    32'd0);
    check("T5 dividend after handoff", 32'(bus.dividend_o), 32'h00C8);
    @(posedge clk_i);
    #1;
    check("T5 no stale accept", 32'(bus.ready_o), 32'd1);

    // T6: reset at the third CALC edge discards the operation
    @(negedge clk_i);
    bus.valid_i = 1'b1;
    bus.quot_i  = 8'hFF;
    bus.div_i   = 8'hFF;
    bus.rem_i   = 8'h10;
    @(posedge clk_i);
    #1;
    bus.valid_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(posedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("T6 reset valid_o",    32'(bus.valid_o),    32'd0);
    check("T6 reset ready_o",    32'(bus.ready_o),    32'd1);
    check("T6 reset dividend_o", 32'(bus.dividend_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_op(8'h02, 8'h03, 8'h01, res, e, lat);
    check("T6 latency",  32'(lat), 32'd8);
    check("T6 dividend", 32'(res), 32'h0007);
    release_result("T6");

    // Random sweep against q*d+r
    for (int n = 0; n < 20; n++) begin
      logic [7:0]  rq, rd, rr;
      logic [15:0] want;
      rq = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      rr = 8'($urandom_range(0, 255));
      want = 16'(rq) * 16'(rd) + 16'(rr);
      run_op(rq, rd, rr, res, e, lat);
      check("rand latency",  32'(lat), 32'd8);
      check("rand dividend", 32'(res), 32'(want));
      check("rand err",      32'(e),   32'(exp_err(rr >= rd)));
      release_result("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
